// File: rtl/div_acc_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : div_acc_seq_if
// Purpose : Bundle of the divide-accelerator sequencer signals. The ctrl
//           side (trigger, operands, abort) and the write-mux side
//           (memory / D-register / PC write strobes) meet here.
// Ports   : master - ctrl / pipeline view (drives trigger, observes results)
//           slave  - sequencer view (observes trigger, drives results)
// Revision: 1.0 - initial release
// ============================================================================
interface div_acc_seq_if #(
  parameter int WIDTH = 16
);
  logic             StartDiv102;
  logic [WIDTH-1:0] Divident;
  logic [WIDTH-1:0] Divisor;
  logic [WIDTH-1:0] ExitPc;
  logic             Abort;
  logic             Busy;
  logic             Reject;
  logic             AccMWrEn;
  logic [WIDTH-1:0] AccMAddr;
  logic [WIDTH-1:0] AccMData;
  logic             AccDWrEn;
  logic [WIDTH-1:0] AccDData;
  logic             AccPcLoad;
  logic [WIDTH-1:0] AccPcVal;
  logic             Done;

  modport master (
    output StartDiv102, Divident, Divisor, ExitPc, Abort,
    input  Busy, Reject, AccMWrEn, AccMAddr, AccMData,
           AccDWrEn, AccDData, AccPcLoad, AccPcVal, Done
  );

  modport slave (
    input  StartDiv102, Divident, Divisor, ExitPc, Abort,
    output Busy, Reject, AccMWrEn, AccMAddr, AccMData,
           AccDWrEn, AccDData, AccPcLoad, AccPcVal, Done
  );
endinterface
`default_nettype wire

// File: rtl/div_acc_seq.sv
`default_nettype none
// ============================================================================
// Module  : div_acc_seq
// Purpose : Divide-loop accelerator sequencer. On an accepted StartDiv102 it
//           latches dividend/divisor/exit PC, runs a restoring shift-subtract
//           divide (one bit per cycle), converts the result to the values the
//           native "subtract until <= 0" loop leaves behind, then writes
//           M[Q_ADDR], M[R_ADDR], D and loads the loop-exit PC.
// Ports   : Clk    - core clock
//           Reset  - asynchronous active-low reset
//           bus    - div_acc_seq_if.slave: trigger/operands/abort in,
//                    Busy/Reject/write strobes/Done out
// Revision: 1.0 - initial release
// ============================================================================
module div_acc_seq #(
  parameter int WIDTH  = 16,
  parameter int Q_ADDR = 1,
  parameter int R_ADDR = 2
) (
  input  wire logic     Clk,
  input  wire logic     Reset,
  div_acc_seq_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_DIV  = 3'd1;
  localparam logic [2:0] S_FIX  = 3'd2;
  localparam logic [2:0] S_WB_Q = 3'd3;
  localparam logic [2:0] S_WB_R = 3'd4;

  logic [2:0]       r_state;
  logic [2:0]       w_nextState;

  logic [WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_exitPc;

  logic             r_reject;
  logic [WIDTH-1:0] r_mAddr;
  logic [WIDTH-1:0] r_mData;
  logic [WIDTH-1:0] r_dData;
  logic [WIDTH-1:0] r_pcVal;

  logic             w_trigger;
  logic             w_opsOk;
  logic [WIDTH-1:0] w_shift;
  logic             w_geq;
  logic [WIDTH-1:0] w_qFinal;
  logic [WIDTH-1:0] w_rFinal;

  logic             w_busy;
  logic             w_mWrEn;
  logic             w_dWrEn;
  logic             w_pcLoad;
  logic             w_done;

  // Abort in the same cycle as the trigger wins: no accept, no reject.
  assign w_trigger = bus.StartDiv102 && !bus.Abort;

  // Both operands must be strictly positive when read as signed.
  assign w_opsOk = !bus.Divident[WIDTH-1] && (bus.Divident != '0) &&
                   !bus.Divisor[WIDTH-1]  && (bus.Divisor  != '0);

  // Partial remainder is always below the divisor (< 2^(WIDTH-1)), so the
  // left shift never loses a set bit.
  assign w_shift = {r_rem[WIDTH-2:0], r_dividend[r_count]};
  assign w_geq   = (w_shift >= r_divisor);

  // The native loop exits one subtraction past floor(X/Y) unless the
  // division was exact, leaving a negative remainder in that case.
  assign w_qFinal = (r_rem == '0) ? r_quot : r_quot + WIDTH'(1);
  assign w_rFinal = (r_rem == '0) ? '0     : r_rem - r_divisor;

  // State register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: if (w_trigger && w_opsOk) w_nextState = S_DIV;
      S_DIV: begin
        if (bus.Abort)              w_nextState = S_IDLE;
        else if (r_count == '0)     w_nextState = S_FIX;
      end
      S_FIX:  w_nextState = bus.Abort ? S_IDLE : S_WB_Q;
      S_WB_Q: w_nextState = S_WB_R;
      S_WB_R: w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    w_busy   = (r_state != S_IDLE);
    w_mWrEn  = 1'b0;
    w_dWrEn  = 1'b0;
    w_pcLoad = 1'b0;
    w_done   = 1'b0;
    case (r_state)
      S_WB_Q: w_mWrEn = 1'b1;
      S_WB_R: begin
        w_mWrEn  = 1'b1;
        w_dWrEn  = 1'b1;
        w_pcLoad = 1'b1;
        w_done   = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath and registered output values. Write data is staged one state
  // ahead so it is stable for the whole write cycle and then simply holds.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_dividend <= '0;
      r_divisor  <= '0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_count    <= '0;
      r_exitPc   <= '0;
      r_reject   <= 1'b0;
      r_mAddr    <= '0;
      r_mData    <= '0;
      r_dData    <= '0;
      r_pcVal    <= '0;
    end else begin
      r_reject <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_trigger) begin
            if (w_opsOk) begin
              r_dividend <= bus.Divident;
              r_divisor  <= bus.Divisor;
              r_exitPc   <= bus.ExitPc;
              r_quot     <= '0;
              r_rem      <= '0;
              r_count    <= CNT_W'(WIDTH - 2);
            end else begin
              r_reject <= 1'b1;
            end
          end
        end
        S_DIV: begin
          r_rem           <= w_geq ? (w_shift - r_divisor) : w_shift;
          r_quot[r_count] <= w_geq;
          r_count         <= r_count - CNT_W'(1);
        end
        S_FIX: begin
          if (!bus.Abort) begin
            r_quot  <= w_qFinal;
            r_rem   <= w_rFinal;
            r_mAddr <= WIDTH'(Q_ADDR);
            r_mData <= w_qFinal;
          end
        end
        S_WB_Q: begin
          r_mAddr <= WIDTH'(R_ADDR);
          r_mData <= r_rem;
          r_dData <= r_rem;
          r_pcVal <= r_exitPc;
        end
        default: ;
      endcase
    end
  end

  assign bus.Busy      = w_busy;
  assign bus.Reject    = r_reject;
  assign bus.AccMWrEn  = w_mWrEn;
  assign bus.AccMAddr  = r_mAddr;
  assign bus.AccMData  = r_mData;
  assign bus.AccDWrEn  = w_dWrEn;
  assign bus.AccDData  = r_dData;
  assign bus.AccPcLoad = w_pcLoad;
  assign bus.AccPcVal  = r_pcVal;
  assign bus.Done      = w_done;

endmodule
`default_nettype wire

// File: tb/tb_div_acc_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_div_acc_seq
// Purpose : Self-checking bench for div_acc_seq. Directed triggers push the
//           expected write-back beats into a queue; a monitor pops and
//           compares them whenever a write strobe appears.
// Revision: 1.0 - initial release
// ============================================================================
module tb_div_acc_seq;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    logic        last;
    logic [15:0] pc;
  } exp_t;

  logic Clk;
  logic Reset;
  int   nAssert = 0;
  int   nFail   = 0;
  int   expRejects = 0;
  exp_t expQ[$];

  div_acc_seq_if #(.WIDTH(16)) bus ();

  div_acc_seq #(.WIDTH(16), .Q_ADDR(1), .R_ADDR(2)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkAllZero(input string name);
    check(name, {5'd0, bus.Busy, bus.Reject, bus.AccMWrEn, bus.AccDWrEn,
                 bus.AccPcLoad, bus.Done, 5'd0}, 16'h0000);
    check({name, "_maddr"}, bus.AccMAddr, 16'h0000);
    check({name, "_mdata"}, bus.AccMData, 16'h0000);
    check({name, "_ddata"}, bus.AccDData, 16'h0000);
    check({name, "_pcval"}, bus.AccPcVal, 16'h0000);
  endtask

  task automatic expectResult(input logic [15:0] q, input logic [15:0] r, input logic [15:0] pc);
    expQ.push_back('{addr: 16'd1, data: q, last: 1'b0, pc: 16'h0});
    expQ.push_back('{addr: 16'd2, data: r, last: 1'b1, pc: pc});
  endtask

  // Called at a negedge; returns at the negedge of cycle 1 after the
  // accepting edge.
  task automatic startDiv(input logic [15:0] x, input logic [15:0] y, input logic [15:0] pc);
    bus.Divident    = x;
    bus.Divisor     = y;
    bus.ExitPc      = pc;
    bus.StartDiv102 = 1'b1;
    @(negedge Clk);
    bus.StartDiv102 = 1'b0;
  endtask

  task automatic waitIdle(input string name, input int expBusy);
    int cnt = 0;
    for (int i = 0; i < 64 && bus.Busy; i++) begin
      cnt++;
      @(negedge Clk);
    end
    check(name, 16'(cnt), 16'(expBusy));
    check({name, "_drained"}, 16'(expQ.size()), 16'd0);
  endtask

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) @(negedge Clk);
  endtask

  // Scoreboard monitor
  always @(negedge Clk) begin
    if (Reset) begin
      if (bus.AccMWrEn) begin
        if (expQ.size() == 0) begin
          nAssert++;
          nFail++;
          $display("FAIL unexpected_write: got addr %h data %h, expected no write", bus.AccMAddr, bus.AccMData);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          check("m_addr",  bus.AccMAddr,  e.addr);
          check("m_data",  bus.AccMData,  e.data);
          check("d_wren",  16'(bus.AccDWrEn),  16'(e.last));
          check("pc_load", 16'(bus.AccPcLoad), 16'(e.last));
          check("done",    16'(bus.Done),      16'(e.last));
          if (e.last) begin
            check("d_data", bus.AccDData, e.data);
            check("pc_val", bus.AccPcVal, e.pc);
          end
        end
      end else if (bus.AccDWrEn || bus.AccPcLoad || bus.Done) begin
        nAssert++;
        nFail++;
        $display("FAIL stray_strobe: got dwr %b pcld %b done %b, expected 0", bus.AccDWrEn, bus.AccPcLoad, bus.Done);
      end
      if (bus.Reject) begin
        nAssert++;
        if (expRejects > 0) begin
          expRejects--;
        end else begin
          nFail++;
          $display("FAIL unexpected_reject: got 1 expected 0 at %0t", $time);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    Reset = 1'b0;
    bus.StartDiv102 = 1'b0;
    bus.Divident    = '0;
    bus.Divisor     = '0;
    bus.ExitPc      = '0;
    bus.Abort       = 1'b0;
    waitCycles(2);
    checkAllZero("reset_state");
    Reset = 1'b1;
    waitCycles(2);

    // Main function, exact division
    expectResult(16'd2000, 16'h0000, 16'h0020);
    startDiv(16'd20000, 16'd10, 16'h0020);
    waitIdle("busy_20000_10", 18);

    // Inexact divisions leave a negative remainder
    expectResult(16'd4, 16'hFFFF, 16'h0031);
    startDiv(16'd7, 16'd2, 16'h0031);
    waitIdle("busy_7_2", 18);

    expectResult(16'd1, 16'hFFFE, 16'h0042);
    startDiv(16'd5, 16'd7, 16'h0042);
    waitIdle("busy_5_7", 18);

    expectResult(16'd1, 16'h0000, 16'h0053);
    startDiv(16'd1, 16'd1, 16'h0053);
    waitIdle("busy_1_1", 18);

    // Largest positive operands
    expectResult(16'd1, 16'h0000, 16'h7FFF);
    startDiv(16'h7FFF, 16'h7FFF, 16'h7FFF);
    waitIdle("busy_max_max", 18);

    // Rejected operands
    expRejects++;
    startDiv(16'd5, 16'd0, 16'h0010);
    check("rej_div0_busy", 16'(bus.Busy), 16'd0);
    @(negedge Clk);
    check("rej_div0_seen", 16'(expRejects), 16'd0);
    check("rej_div0_idle", 16'(bus.Busy), 16'd0);

    expRejects++;
    startDiv(16'h8000, 16'd3, 16'h0010);
    check("rej_neg_busy", 16'(bus.Busy), 16'd0);
    @(negedge Clk);
    check("rej_neg_seen", 16'(expRejects), 16'd0);

    expRejects++;
    startDiv(16'd0, 16'd3, 16'h0010);
    check("rej_zero_busy", 16'(bus.Busy), 16'd0);
    @(negedge Clk);
    check("rej_zero_seen", 16'(expRejects), 16'd0);

    // Abort together with trigger in idle: neither accept nor reject
    bus.Abort = 1'b1;
    startDiv(16'd5, 16'd1, 16'h0010);
    bus.Abort = 1'b0;
    check("abort_trig_busy", 16'(bus.Busy), 16'd0);
    waitCycles(2);

    // Abort in the 5th S_DIV cycle
    startDiv(16'd100, 16'd7, 16'h0099);
    waitCycles(4);
    bus.Abort = 1'b1;
    @(negedge Clk);
    bus.Abort = 1'b0;
    check("abort_div_busy", 16'(bus.Busy), 16'd0);
    waitCycles(20);

    expectResult(16'd3, 16'h0000, 16'h0064);
    startDiv(16'd9, 16'd3, 16'h0064);
    waitIdle("busy_9_3", 18);

    // Second trigger while dividing is ignored
    expectResult(16'd2000, 16'h0000, 16'h0075);
    startDiv(16'd20000, 16'd10, 16'h0075);
    waitCycles(3);
    startDiv(16'd100, 16'd7, 16'h0111);
    waitIdle("busy_ignored_trig", 14);

    // Abort during S_WB_Q: write-back still completes
    expectResult(16'd1, 16'h0000, 16'h0086);
    startDiv(16'd1, 16'd1, 16'h0086);
    waitCycles(16);
    check("wbq_busy", 16'(bus.Busy), 16'd1);
    bus.Abort = 1'b1;
    @(negedge Clk);
    bus.Abort = 1'b0;
    waitCycles(2);
    check("abort_wbq_drained", 16'(expQ.size()), 16'd0);

    // Reset during S_WB_Q: only the quotient write occurs
    expQ.push_back('{addr: 16'd1, data: 16'd2000, last: 1'b0, pc: 16'h0});
    startDiv(16'd20000, 16'd10, 16'h0097);
    waitCycles(16);
    #2 Reset = 1'b0;
    #1 checkAllZero("async_reset");
    @(negedge Clk);
    checkAllZero("reset_hold");
    Reset = 1'b1;
    waitCycles(3);
    check("post_reset_busy", 16'(bus.Busy), 16'd0);
    check("post_reset_drained", 16'(expQ.size()), 16'd0);

    // Still functional after the mid-operation reset
    expectResult(16'd4, 16'hFFFF, 16'h00A8);
    startDiv(16'd7, 16'd2, 16'h00A8);
    waitIdle("busy_after_reset", 18);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/div_acc_seq.md
Name: div_acc_seq

Overview:
- Sequencer for the hardware divide accelerator.
- Triggered when the front-end pattern matcher fires StartDiv102 on the software divide loop (Q = M[1]; M[2] -= M[3] until M[2] <= 0).
- Latches dividend and divisor, runs an iterative shift-subtract divide, then drives the architectural writes the loop would have left: M[Q_ADDR], M[R_ADDR] and D. Loads the loop-exit PC and holds fetch/decode while busy.
- Sits between ctrl (trigger/operands) and the memory/D-register/PC write muxes.

Parameters:
- WIDTH, 16, data width of operands, results and PC.
- Q_ADDR, 1, memory address receiving the quotient.
- R_ADDR, 2, memory address receiving the final (loop-exit) remainder.

Ports:
- Clk  in  1  core clock.
- Reset  in  1  asynchronous, active-low reset (asserted when 0).
- StartDiv102  in  1  divide-loop match pulse from ctrl.
- Divident  in  WIDTH  dividend value, valid with StartDiv102.
- Divisor  in  WIDTH  divisor value, valid with StartDiv102.
- ExitPc  in  WIDTH  PC of the first instruction after the loop's JGT, valid with StartDiv102.
- Abort  in  1  pipeline flush (jump resolved in 103); cancels a running divide.
- Busy  out  1  accelerator owns the pipeline; fetch/decode hold, native writes suppressed.
- Reject  out  1  one-cycle pulse: trigger refused, program runs natively.
- AccMWrEn  out  1  memory write enable.
- AccMAddr  out  WIDTH  memory write address.
- AccMData  out  WIDTH  memory write data.
- AccDWrEn  out  1  D-register write enable.
- AccDData  out  WIDTH  D-register write data.
- AccPcLoad  out  1  PC load strobe.
- AccPcVal  out  WIDTH  PC load value.
- Done  out  1  one-cycle pulse on completion.

Behaviour:
- Reset (Reset=0, async): state S_IDLE; every output 0; internal registers (dividend, divisor, quotient, partial remainder, iteration counter, exit PC) cleared.
- States: S_IDLE, S_DIV, S_FIX, S_WB_Q, S_WB_R.
- S_IDLE, StartDiv102=1:
  - Accept when Divident and Divisor, read as signed, are both in 1..2^(WIDTH-1)-1. Latch both operands and ExitPc; clear quotient and remainder; counter=WIDTH-2; go to S_DIV.
  - Otherwise pulse Reject for 1 cycle, stay in S_IDLE, drive no writes.
- S_DIV: one restoring shift-subtract step per cycle over the WIDTH-1 magnitude bits, MSB first. Counter decrements each cycle. At counter=0, after that step, go to S_FIX. This is exactly WIDTH-1 cycles (15 at WIDTH=16).
- S_FIX, 1 cycle, with q0 = floor(X/Y) and r0 = X mod Y:
  - r0 == 0: Q = q0, R = 0.
  - r0 != 0: Q = q0+1, R = r0 - Y (two's complement, WIDTH bits, negative).
  - This matches the native loop's exit values.
- S_WB_Q, 1 cycle: AccMWrEn=1, AccMAddr=Q_ADDR, AccMData=Q.
- S_WB_R, 1 cycle, then go to S_IDLE:
  - AccMWrEn=1, AccMAddr=R_ADDR, AccMData=R.
  - AccDWrEn=1, AccDData=R.
  - AccPcLoad=1, AccPcVal=latched ExitPc.
  - Done=1.
- Latency and Busy: with the trigger accepted at edge 0, Busy is 1 in cycles 1..WIDTH+2 (18 cycles at WIDTH=16) and 0 in S_IDLE.
- Write-enable outputs (AccMWrEn, AccDWrEn, AccPcLoad, Done) are 0 outside the states listed above; the data/address outputs they qualify hold their last value.
- StartDiv102 while Busy: ignored. No Reject, latched operands unchanged.
- Abort:
  - In S_DIV or S_FIX: return to S_IDLE next cycle, no writes, no Done, Busy falls.
  - In S_WB_Q or S_WB_R: ignored; write-back completes atomically.
  - Abort and StartDiv102 together in S_IDLE: trigger ignored, no Reject.
- Reset asserted mid-operation: immediate return to S_IDLE with all outputs 0; no partial write-back.
- Arithmetic: the partial remainder is WIDTH bits wide, unsigned compare/subtract. Quotient +1 cannot overflow because q0 <= 2^(WIDTH-1)-1.

Test Plan:
- Divident=20000, Divisor=10, ExitPc=0x0020 -> Busy for 18 cycles. S_WB_Q: M[1]=2000. S_WB_R: M[2]=0, D=0, PC=0x0020. Done pulses in the same cycle as the last write.
- 7/2 -> Q=4, M[2]=D=0xFFFF. 5/7 -> Q=1, M[2]=D=0xFFFE. 1/1 -> Q=1, R=0.
- Divisor=0, Divident=0x8000 and Divident=0 (each separately) -> single-cycle Reject, Busy stays 0, no writes.
- Abort in the 5th S_DIV cycle -> S_IDLE next cycle, no AccMWrEn/AccDWrEn/AccPcLoad, no Done. A new StartDiv102 (9/3) afterwards -> Q=3, R=0.
- Second StartDiv102 (100/7) during S_DIV of 20000/10 -> ignored, results 2000/0. Abort asserted during S_WB_Q -> both writes still complete.
- Reset driven to 0 during S_WB_Q -> all outputs 0 asynchronously, no M[R_ADDR] write. After release, state is S_IDLE.
